axi_wr_outstanding_fsm: RTL and testbench

- Parametrised write-path AXI protocol model: AW, W and B channels, with up to MAX_OUT outstanding write bursts. Successor to the single-outstanding channel FSMs.
- Adds ID tracking, per-beat address generation (FIXED/INCR/WRAP), in-order B responses carrying ID, and SLVERR on illegal bursts.
- Sits between the stimulus/ILA side (*_in inputs) and the registered axi_* signals used by the property checker.

---
 rtl/axi_wr_outstanding_fsm.sv | 342 ++++++++++++++++++++++++++++++++++
 tb/tb_axi_wr_outstanding_fsm.sv | 449 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_wr_outstanding_fsm.sv
// ---------------------------------------------------------------------------
// axi_wr_outstanding_fsm
//
// Write-path AXI protocol model with up to MAX_OUT outstanding bursts. Takes
// raw stimulus on the *_in inputs and produces registered axi_* signals for a
// property checker. It tracks IDs, generates per-beat addresses for FIXED,
// INCR and WRAP bursts, returns B responses in AW order, and flags illegal
// bursts with SLVERR.
//
// Ports:
//   axi_aclk, rst_n          clock, synchronous active-low reset
//   aw*_in / axi_aw*         AW stimulus in, registered AW channel out
//   w*_in / axi_w*           W stimulus in, registered W channel out
//   axi_wlast                last beat of the head command
//   axi_wbeat_addr           address of the current W beat
//   bready_in / axi_b*       B stimulus in, registered B channel out
//   outstanding              bursts accepted on AW but not yet done on B
// ---------------------------------------------------------------------------
module axi_wr_outstanding_fsm #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 64,
    parameter int unsigned IDW     = 4,
    parameter int unsigned MAX_OUT = 4
) (
    input  logic                     axi_aclk,
    input  logic                     rst_n,
    input  logic [AW-1:0]            awaddr_in,
    input  logic [IDW-1:0]           awid_in,
    input  logic [7:0]               awlen_in,
    input  logic [2:0]               awsize_in,
    input  logic [1:0]               awburst_in,
    input  logic                     awvalid_in,
    output logic [AW-1:0]            axi_awaddr,
    output logic [IDW-1:0]           axi_awid,
    output logic [7:0]               axi_awlen,
    output logic [2:0]               axi_awsize,
    output logic [1:0]               axi_awburst,
    output logic                     axi_awvalid,
    output logic                     axi_awready,
    input  logic [DW-1:0]            wdata_in,
    input  logic [DW/8-1:0]          wstrb_in,
    input  logic                     wvalid_in,
    input  logic                     wready_in,
    output logic [DW-1:0]            axi_wdata,
    output logic [DW/8-1:0]          axi_wstrb,
    output logic                     axi_wvalid,
    output logic                     axi_wready,
    output logic                     axi_wlast,
    output logic [AW-1:0]            axi_wbeat_addr,
    input  logic                     bready_in,
    output logic [IDW-1:0]           axi_bid,
    output logic [1:0]               axi_bresp,
    output logic                     axi_bvalid,
    output logic                     axi_bready,
    output logic [$clog2(MAX_OUT):0] outstanding
);

    localparam int unsigned LOG2B = $clog2(DW/8);
    localparam int unsigned PW    = $clog2(MAX_OUT);
    localparam int unsigned CW    = PW + 1;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [AW-1:0]  addr;
        logic [7:0]     len;
        logic [2:0]     size;
        logic [1:0]     burst;
        logic           err;
    } cmd_t;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic           err;
    } bent_t;

    typedef enum logic {AW_IDLE, AW_PEND} aw_state_t;
    typedef enum logic {B_IDLE, B_RESP} b_state_t;

    // ---------------- AW channel ----------------
    aw_state_t      aw_state_q, aw_state_d;
    logic [AW-1:0]  awaddr_q, awaddr_d;
    logic [IDW-1:0] awid_q, awid_d;
    logic [7:0]     awlen_q, awlen_d;
    logic [2:0]     awsize_q, awsize_d;
    logic [1:0]     awburst_q, awburst_d;
    logic           aw_load, aw_hs, aw_err;
    logic [AW-1:0]  aw_step;
    logic [31:0]    incr_end;
    logic           wrap_len_ok;

    // ---------------- command FIFO ----------------
    cmd_t           cmd_mem_q [MAX_OUT];
    logic [PW-1:0]  cmd_wr_q, cmd_wr_d, cmd_rd_q, cmd_rd_d;
    logic [CW-1:0]  cmd_cnt_q, cmd_cnt_d;
    logic           cmd_push, cmd_pop, cmd_nonempty;
    cmd_t           cmd_push_data, head;

    // ---------------- W channel ----------------
    logic           wvalid_q, wvalid_d, wready_q, wready_d;
    logic [DW-1:0]  wdata_q, wdata_d;
    logic [DW/8-1:0] wstrb_q, wstrb_d;
    logic [7:0]     beat_cnt_q, beat_cnt_d;
    logic [AW-1:0]  beat_addr_q, beat_addr_d;
    logic [AW-1:0]  cur_addr, next_addr, incr_addr, wrap_bytes, wrap_lower;
    logic           w_hs, wlast;

    // ---------------- B channel ----------------
    bent_t          b_mem_q [MAX_OUT];
    logic [PW-1:0]  b_wr_q, b_wr_d, b_rd_q, b_rd_d;
    logic [CW-1:0]  b_cnt_q, b_cnt_d;
    logic           b_push, b_load, b_hs;
    b_state_t       b_state_q, b_state_d;
    logic [IDW-1:0] bid_q, bid_d;
    logic [1:0]     bresp_q, bresp_d;
    logic           bready_q, bready_d;
    logic [CW-1:0]  out_q, out_d;

    // Ready depends only on registered counts; a pop in the same cycle does
    // not open a slot until the following cycle.
    assign axi_awready = (cmd_cnt_q != CW'(MAX_OUT)) && (out_q != CW'(MAX_OUT));
    assign aw_hs       = (aw_state_q == AW_PEND) && axi_awready;

    always_comb begin
        aw_state_d = aw_state_q;
        awaddr_d   = awaddr_q;
        awid_d     = awid_q;
        awlen_d    = awlen_q;
        awsize_d   = awsize_q;
        awburst_d  = awburst_q;
        aw_load    = 1'b0;
        unique case (aw_state_q)
            AW_IDLE: begin
                if (awvalid_in) begin
                    aw_load    = 1'b1;
                    aw_state_d = AW_PEND;
                end
            end
            AW_PEND: begin
                if (aw_hs) begin
                    if (awvalid_in) aw_load = 1'b1;
                    else            aw_state_d = AW_IDLE;
                end
            end
            default: aw_state_d = AW_IDLE;
        endcase
        if (aw_load) begin
            awaddr_d  = awaddr_in;
            awid_d    = awid_in;
            awlen_d   = awlen_in;
            awsize_d  = awsize_in;
            awburst_d = awburst_in;
        end
    end

    // Legality of the registered AW payload, evaluated at push time.
    always_comb begin
        aw_step     = AW'(1) << awsize_q;
        incr_end    = 32'(awaddr_q[11:0]) + ((32'(awlen_q) + 32'd1) << awsize_q);
        wrap_len_ok = (awlen_q == 8'd1) || (awlen_q == 8'd3) ||
                      (awlen_q == 8'd7) || (awlen_q == 8'd15);
        aw_err      = (32'(awsize_q) > LOG2B) ||
                      (awburst_q == 2'b10 && !wrap_len_ok) ||
                      (awburst_q == 2'b10 && ((awaddr_q & (aw_step - AW'(1))) != '0)) ||
                      (awburst_q == 2'b01 && incr_end > 32'd4096) ||
                      (awburst_q == 2'b11);
    end

    // ---------------- command FIFO control ----------------
    assign head         = cmd_mem_q[cmd_rd_q];
    assign cmd_nonempty = (cmd_cnt_q != '0);
    assign cmd_push     = aw_hs;
    assign cmd_pop      = w_hs && wlast;

    always_comb begin
        cmd_push_data = '{id: awid_q, addr: awaddr_q, len: awlen_q,
                          size: awsize_q, burst: awburst_q, err: aw_err};
        cmd_wr_d  = cmd_push ? cmd_wr_q + 1'b1 : cmd_wr_q;
        cmd_rd_d  = cmd_pop  ? cmd_rd_q + 1'b1 : cmd_rd_q;
        cmd_cnt_d = cmd_cnt_q;
        if (cmd_push && !cmd_pop)      cmd_cnt_d = cmd_cnt_q + CW'(1);
        else if (cmd_pop && !cmd_push) cmd_cnt_d = cmd_cnt_q - CW'(1);
    end

    // ---------------- W channel ----------------
    assign w_hs  = wvalid_q && wready_q;
    assign wlast = cmd_nonempty && (beat_cnt_q == head.len);

    // The first beat reads the address straight from the head command, so
    // beat_addr_q only needs to hold addresses of later beats.
    always_comb begin
        cur_addr   = (beat_cnt_q == 8'd0) ? head.addr : beat_addr_q;
        incr_addr  = cur_addr + (AW'(1) << head.size);
        wrap_bytes = (AW'(head.len) + AW'(1)) << head.size;
        wrap_lower = cur_addr & ~(wrap_bytes - AW'(1));
        unique case (head.burst)
            2'b00:   next_addr = cur_addr;
            2'b10:   next_addr = (incr_addr == wrap_lower + wrap_bytes) ? wrap_lower : incr_addr;
            default: next_addr = incr_addr;
        endcase
    end

    always_comb begin
        wvalid_d    = wvalid_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        beat_cnt_d  = beat_cnt_q;
        beat_addr_d = beat_addr_q;
        if (!wvalid_q || w_hs) begin
            wvalid_d = wvalid_in;
            wdata_d  = wdata_in;
            wstrb_d  = wstrb_in;
        end
        if (w_hs) begin
            if (wlast) begin
                beat_cnt_d = 8'd0;
            end else begin
                beat_cnt_d  = beat_cnt_q + 8'd1;
                beat_addr_d = next_addr;
            end
        end
        wready_d = wready_in && (cmd_cnt_d != '0);
    end

    // ---------------- B channel ----------------
    assign b_push = cmd_pop;
    assign b_hs   = (b_state_q == B_RESP) && bready_q;

    // The output register holds the presented response; the FIFO holds the
    // ones behind it, so a handshake can refill from the FIFO with no bubble.
    always_comb begin
        b_state_d = b_state_q;
        bid_d     = bid_q;
        bresp_d   = bresp_q;
        b_load    = 1'b0;
        unique case (b_state_q)
            B_IDLE: begin
                if (b_cnt_q != '0) begin
                    b_load    = 1'b1;
                    b_state_d = B_RESP;
                end
            end
            B_RESP: begin
                if (b_hs) begin
                    if (b_cnt_q != '0) b_load = 1'b1;
                    else               b_state_d = B_IDLE;
                end
            end
            default: b_state_d = B_IDLE;
        endcase
        if (b_load) begin
            bid_d   = b_mem_q[b_rd_q].id;
            bresp_d = b_mem_q[b_rd_q].err ? 2'b10 : 2'b00;
        end
        b_wr_d  = b_push ? b_wr_q + 1'b1 : b_wr_q;
        b_rd_d  = b_load ? b_rd_q + 1'b1 : b_rd_q;
        b_cnt_d = b_cnt_q;
        if (b_push && !b_load)      b_cnt_d = b_cnt_q + CW'(1);
        else if (b_load && !b_push) b_cnt_d = b_cnt_q - CW'(1);
        bready_d = bready_in;
        out_d    = out_q;
        if (aw_hs && !b_hs)      out_d = out_q + CW'(1);
        else if (b_hs && !aw_hs) out_d = out_q - CW'(1);
    end

    // ---------------- registers ----------------
    always_ff @(posedge axi_aclk) begin
        if (cmd_push) cmd_mem_q[cmd_wr_q] <= cmd_push_data;
        if (b_push)   b_mem_q[b_wr_q]     <= '{id: head.id, err: head.err};
    end

    always_ff @(posedge axi_aclk) begin
        if (!rst_n) begin
            aw_state_q  <= AW_IDLE;
            awaddr_q    <= '0;
            awid_q      <= '0;
            awlen_q     <= '0;
            awsize_q    <= '0;
            awburst_q   <= '0;
            cmd_wr_q    <= '0;
            cmd_rd_q    <= '0;
            cmd_cnt_q   <= '0;
            wvalid_q    <= 1'b0;
            wready_q    <= 1'b0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            beat_cnt_q  <= '0;
            beat_addr_q <= '0;
            b_state_q   <= B_IDLE;
            bid_q       <= '0;
            bresp_q     <= '0;
            bready_q    <= 1'b0;
            b_wr_q      <= '0;
            b_rd_q      <= '0;
            b_cnt_q     <= '0;
            out_q       <= '0;
        end else begin
            aw_state_q  <= aw_state_d;
            awaddr_q    <= awaddr_d;
            awid_q      <= awid_d;
            awlen_q     <= awlen_d;
            awsize_q    <= awsize_d;
            awburst_q   <= awburst_d;
            cmd_wr_q    <= cmd_wr_d;
            cmd_rd_q    <= cmd_rd_d;
            cmd_cnt_q   <= cmd_cnt_d;
            wvalid_q    <= wvalid_d;
            wready_q    <= wready_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            beat_cnt_q  <= beat_cnt_d;
            beat_addr_q <= beat_addr_d;
            b_state_q   <= b_state_d;
            bid_q       <= bid_d;
            bresp_q     <= bresp_d;
            bready_q    <= bready_d;
            b_wr_q      <= b_wr_d;
            b_rd_q      <= b_rd_d;
            b_cnt_q     <= b_cnt_d;
            out_q       <= out_d;
        end
    end

    // ---------------- outputs ----------------
    assign axi_awaddr     = awaddr_q;
    assign axi_awid       = awid_q;
    assign axi_awlen      = awlen_q;
    assign axi_awsize     = awsize_q;
    assign axi_awburst    = awburst_q;
    assign axi_awvalid    = (aw_state_q == AW_PEND);
    assign axi_wdata      = wdata_q;
    assign axi_wstrb      = wstrb_q;
    assign axi_wvalid     = wvalid_q;
    assign axi_wready     = wready_q;
    assign axi_wlast      = wlast;
    assign axi_wbeat_addr = cmd_nonempty ? cur_addr : '0;
    assign axi_bid        = bid_q;
    assign axi_bresp      = bresp_q;
    assign axi_bvalid     = (b_state_q == B_RESP);
    assign axi_bready     = bready_q;
    assign outstanding    = out_q;

endmodule

// File: tb/tb_axi_wr_outstanding_fsm.sv
// ---------------------------------------------------------------------------
// tb_axi_wr_outstanding_fsm
//
// Scoreboard bench: expected beat addresses / wlast and expected B responses
// are queued when AW stimulus is issued and popped by a negedge monitor when
// the DUT shows a pending handshake. Scenario tasks add direct checks.
// ---------------------------------------------------------------------------
module tb_axi_wr_outstanding_fsm;

    localparam int unsigned AW      = 32;
    localparam int unsigned DW      = 64;
    localparam int unsigned IDW     = 4;
    localparam int unsigned MAX_OUT = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic [AW-1:0]  awaddr_in;
    logic [IDW-1:0] awid_in;
    logic [7:0]     awlen_in;
    logic [2:0]     awsize_in;
    logic [1:0]     awburst_in;
    logic           awvalid_in;
    logic [AW-1:0]  axi_awaddr;
    logic [IDW-1:0] axi_awid;
    logic [7:0]     axi_awlen;
    logic [2:0]     axi_awsize;
    logic [1:0]     axi_awburst;
    logic           axi_awvalid, axi_awready;
    logic [DW-1:0]  wdata_in;
    logic [DW/8-1:0] wstrb_in;
    logic           wvalid_in, wready_in;
    logic [DW-1:0]  axi_wdata;
    logic [DW/8-1:0] axi_wstrb;
    logic           axi_wvalid, axi_wready, axi_wlast;
    logic [AW-1:0]  axi_wbeat_addr;
    logic           bready_in;
    logic [IDW-1:0] axi_bid;
    logic [1:0]     axi_bresp;
    logic           axi_bvalid, axi_bready;
    logic [$clog2(MAX_OUT):0] outstanding;

    axi_wr_outstanding_fsm #(.AW(AW), .DW(DW), .IDW(IDW), .MAX_OUT(MAX_OUT)) dut (
        .axi_aclk(clk), .rst_n(rst_n),
        .awaddr_in(awaddr_in), .awid_in(awid_in), .awlen_in(awlen_in),
        .awsize_in(awsize_in), .awburst_in(awburst_in), .awvalid_in(awvalid_in),
        .axi_awaddr(axi_awaddr), .axi_awid(axi_awid), .axi_awlen(axi_awlen),
        .axi_awsize(axi_awsize), .axi_awburst(axi_awburst),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .wdata_in(wdata_in), .wstrb_in(wstrb_in), .wvalid_in(wvalid_in),
        .wready_in(wready_in), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wlast(axi_wlast),
        .axi_wbeat_addr(axi_wbeat_addr), .bready_in(bready_in),
        .axi_bid(axi_bid), .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid),
        .axi_bready(axi_bready), .outstanding(outstanding)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        last;
        bit          chk;
    } wexp_t;

    wexp_t      w_q[$];
    logic [5:0] b_q[$];
    int         n_cmp = 0;
    int         n_err = 0;
    int         b_hs_seen = 0;

    // ---------------- reference model ----------------
    function automatic logic exp_err(input logic [31:0] a, input logic [7:0] len,
                                     input logic [2:0] sz, input logic [1:0] bu);
        int unsigned bytes;
        bytes = (32'(len) + 1) << sz;
        if (sz > 3) return 1'b1;
        if (bu == 2'b11) return 1'b1;
        if (bu == 2'b10 && !(len == 1 || len == 3 || len == 7 || len == 15)) return 1'b1;
        if (bu == 2'b10 && (a % (32'd1 << sz)) != 0) return 1'b1;
        if (bu == 2'b01 && (a & 32'hFFF) + bytes > 4096) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] exp_addr(input logic [31:0] a, input logic [7:0] len,
                                             input logic [2:0] sz, input logic [1:0] bu,
                                             input int unsigned i);
        int unsigned step, wb, base;
        step = 32'd1 << sz;
        wb   = (32'(len) + 1) * step;
        case (bu)
            2'b00:   return a;
            2'b10: begin
                base = a - (a % wb);
                return base + (((a - base) + i * step) % wb);
            end
            default: return a + i * step;
        endcase
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            if (axi_wvalid && axi_wready) begin
                if (w_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL w_unexpected: beat addr %h with no expected beat", axi_wbeat_addr);
                end else begin
                    wexp_t e;
                    e = w_q.pop_front();
                    if (e.chk) begin
                        n_cmp++;
                        if (axi_wbeat_addr !== e.addr) begin
                            n_err++;
                            $display("FAIL w_addr: got %h want %h", axi_wbeat_addr, e.addr);
                        end
                    end
                    n_cmp++;
                    if (axi_wlast !== e.last) begin
                        n_err++;
                        $display("FAIL w_last: got %b want %b (addr %h)", axi_wlast, e.last, e.addr);
                    end
                end
            end
            if (axi_bvalid && axi_bready) begin
                b_hs_seen++;
                n_cmp++;
                if (b_q.size() == 0) begin
                    n_err++;
                    $display("FAIL b_unexpected: bid %h bresp %b", axi_bid, axi_bresp);
                end else begin
                    logic [5:0] eb;
                    eb = b_q.pop_front();
                    if ({axi_bid, axi_bresp} !== eb) begin
                        n_err++;
                        $display("FAIL b_resp: got id %h resp %b want id %h resp %b",
                                 axi_bid, axi_bresp, eb[5:2], eb[1:0]);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    task automatic aw_send(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                           input logic [2:0] sz, input logic [1:0] bu, input int budget);
        bit ok;
        logic e;
        wexp_t we;
        e = exp_err(a, len, sz, bu);
        for (int unsigned i = 0; i <= 32'(len); i++) begin
            we.addr = exp_addr(a, len, sz, bu, i);
            we.last = (i == 32'(len));
            we.chk  = (bu == 2'b00) || (bu == 2'b01) || (bu == 2'b10 && !e);
            w_q.push_back(we);
        end
        b_q.push_back({id, e ? 2'b10 : 2'b00});
        awaddr_in = a; awid_in = id; awlen_in = len; awsize_in = sz; awburst_in = bu;
        awvalid_in = 1'b1;
        @(posedge clk); #1;
        awvalid_in = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (axi_awvalid && axi_awready) begin
                @(posedge clk); #1;
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL aw_timeout: id %h not accepted within %0d cycles", id, budget);
        end
    endtask

    task automatic w_beats(input int n, input int budget);
        int cnt;
        bit hs, ld, ok;
        cnt = 0; ok = 1'b0;
        wvalid_in = 1'b1; wstrb_in = '1;
        for (int i = 0; i < budget; i++) begin
            hs = axi_wvalid && axi_wready;
            if (hs) begin
                cnt++;
                if (cnt == n) wvalid_in = 1'b0;
            end
            ld = !axi_wvalid || hs;
            @(posedge clk); #1;
            if (ld) wdata_in = wdata_in + 64'd1;
            if (cnt == n) begin
                ok = 1'b1;
                break;
            end
        end
        wvalid_in = 1'b0;
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL w_timeout: %0d of %0d beats in %0d cycles", cnt, n, budget);
        end
    endtask

    task automatic drain(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (w_q.size() == 0 && b_q.size() == 0 && outstanding == 0) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL drain: w_q %0d b_q %0d outstanding %0d", w_q.size(), b_q.size(), outstanding);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({axi_awvalid, axi_wvalid, axi_wready, axi_wlast, axi_bvalid, axi_bready} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_valids: got %b want 000000",
                     {axi_awvalid, axi_wvalid, axi_wready, axi_wlast, axi_bvalid, axi_bready});
        end
        n_cmp++;
        if (axi_awready !== 1'b1) begin
            n_err++; $display("FAIL reset_awready: got %b want 1", axi_awready);
        end
        n_cmp++;
        if (outstanding !== 3'd0) begin
            n_err++; $display("FAIL reset_outstanding: got %0d want 0", outstanding);
        end
        n_cmp++;
        if ({axi_awaddr, axi_wbeat_addr, axi_bid, axi_bresp, axi_wdata} !== '0) begin
            n_err++; $display("FAIL reset_payload: awaddr %h beat %h bid %h bresp %b wdata %h",
                              axi_awaddr, axi_wbeat_addr, axi_bid, axi_bresp, axi_wdata);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single_incr();
        aw_send(32'h1000, 4'h3, 8'd3, 3'd3, 2'b01, 20);
        w_beats(4, 30);
        n_cmp++;
        if (axi_bvalid !== 1'b0) begin
            n_err++; $display("FAIL single_b_early: bvalid %b want 0", axi_bvalid);
        end
        @(posedge clk); #1;
        n_cmp++;
        if ({axi_bvalid, axi_bid, axi_bresp} !== {1'b1, 4'h3, 2'b00}) begin
            n_err++; $display("FAIL single_b: got v%b id %h resp %b want v1 id 3 resp 00",
                              axi_bvalid, axi_bid, axi_bresp);
        end
        drain(20);
    endtask

    task automatic test_wrap_fixed();
        aw_send(32'h1018, 4'h4, 8'd3, 3'd3, 2'b10, 20);
        w_beats(4, 30);
        aw_send(32'h2000, 4'h5, 8'd2, 3'd2, 2'b00, 20);
        w_beats(3, 30);
        drain(20);
    endtask

    task automatic test_back_pressure();
        int b_base;
        for (int unsigned k = 1; k <= 4; k++)
            aw_send(32'h8000 + 32'(k) * 32'h100, 4'(k), 8'd0, 3'd3, 2'b01, 20);
        n_cmp++;
        if (outstanding !== 3'd4 || axi_awready !== 1'b0) begin
            n_err++; $display("FAIL bp_full: outstanding %0d awready %b want 4 0", outstanding, axi_awready);
        end
        b_base = b_hs_seen;
        fork
            aw_send(32'h8500, 4'h5, 8'd0, 3'd3, 2'b01, 80);
            begin
                bit seen;
                seen = 1'b0;
                for (int i = 0; i < 80; i++) begin
                    if (axi_awvalid && axi_awready) begin
                        seen = 1'b1;
                        n_cmp++;
                        if (b_hs_seen - b_base < 1) begin
                            n_err++; $display("FAIL bp_early_accept: B handshakes %0d want >=1", b_hs_seen - b_base);
                        end
                        break;
                    end
                    @(posedge clk); #1;
                end
                n_cmp++;
                if (!seen) begin
                    n_err++; $display("FAIL bp_accept_timeout: 5th AW never accepted");
                end
            end
            begin
                repeat (3) begin @(posedge clk); #1; end
                n_cmp++;
                if (axi_awready !== 1'b0) begin
                    n_err++; $display("FAIL bp_hold: awready %b want 0", axi_awready);
                end
                w_beats(5, 80);
            end
        join
        drain(40);
    endtask

    task automatic test_data_first();
        wdata_in = 64'hA5A5_0000_0000_0001; wstrb_in = '1; wvalid_in = 1'b1;
        @(posedge clk); #1;
        wdata_in = 64'hA5A5_0000_0000_0002;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (axi_wready !== 1'b0 || axi_wdata !== 64'hA5A5_0000_0000_0001) begin
                n_err++; $display("FAIL dfirst_hold: wready %b wdata %h want 0 a5a5000000000001", axi_wready, axi_wdata);
            end
            @(posedge clk); #1;
        end
        aw_send(32'h6000, 4'h9, 8'd0, 3'd3, 2'b01, 20);
        n_cmp++;
        if ({axi_wvalid, axi_wready} !== 2'b11 || axi_wdata !== 64'hA5A5_0000_0000_0001) begin
            n_err++; $display("FAIL dfirst_hs: wvalid %b wready %b wdata %h want 1 1 a5a5000000000001",
                              axi_wvalid, axi_wready, axi_wdata);
        end
        wvalid_in = 1'b0;
        @(posedge clk); #1;
        drain(20);
    endtask

    task automatic test_errors();
        aw_send(32'h3000, 4'hA, 8'd1, 3'd4, 2'b01, 20);   // size above bus width
        w_beats(2, 30);
        aw_send(32'h4000, 4'hB, 8'd2, 3'd3, 2'b10, 20);   // WRAP with len 2
        w_beats(3, 30);
        aw_send(32'h0FF8, 4'hC, 8'd1, 3'd3, 2'b01, 20);   // crosses 4 KB
        w_beats(2, 30);
        aw_send(32'h0FF0, 4'hD, 8'd1, 3'd3, 2'b01, 20);   // ends exactly at 4 KB
        w_beats(2, 30);
        aw_send(32'h0100, 4'hE, 8'd0, 3'd3, 2'b11, 20);   // reserved burst type
        w_beats(1, 30);
        drain(30);
    endtask

    task automatic test_back_to_back();
        bready_in = 1'b0;
        fork
            begin
                aw_send(32'h9000, 4'h1, 8'd1, 3'd3, 2'b01, 20);
                aw_send(32'h9100, 4'h2, 8'd1, 3'd3, 2'b01, 20);
                aw_send(32'h9200, 4'h3, 8'd1, 3'd3, 2'b01, 20);
            end
            w_beats(6, 60);
            begin
                bit done;
                done = 1'b0;
                for (int i = 0; i < 80; i++) begin
                    if (w_q.size() == 0 && outstanding == 3'd3) begin done = 1'b1; break; end
                    @(posedge clk); #1;
                end
                n_cmp++;
                if (!done) begin
                    n_err++; $display("FAIL b2b_wait: w_q %0d outstanding %0d", w_q.size(), outstanding);
                end
                repeat (2) begin @(posedge clk); #1; end
                bready_in = 1'b1;
                @(posedge clk); #1;
                for (int k = 0; k < 4; k++) begin
                    n_cmp++;
                    if (axi_bvalid !== (k < 3)) begin
                        n_err++; $display("FAIL b2b_bvalid: cycle %0d bvalid %b want %b", k, axi_bvalid, (k < 3));
                    end
                    @(posedge clk); #1;
                end
            end
        join
        drain(20);
    endtask

    task automatic test_reset_mid();
        int cnt;
        aw_send(32'h7000, 4'h7, 8'd3, 3'd3, 2'b01, 20);
        cnt = 0;
        wvalid_in = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (axi_wvalid && axi_wready) begin
                cnt++;
                if (cnt == 2) wvalid_in = 1'b0;
            end
            @(posedge clk); #1;
            if (cnt == 2) break;
        end
        rst_n = 1'b0;
        w_q.delete();
        b_q.delete();
        @(posedge clk); #1;
        n_cmp++;
        if ({axi_awvalid, axi_wvalid, axi_wready, axi_wlast, axi_bvalid, axi_awready} !== 6'b000001) begin
            n_err++; $display("FAIL rmid_ctrl: got %b want 000001",
                              {axi_awvalid, axi_wvalid, axi_wready, axi_wlast, axi_bvalid, axi_awready});
        end
        n_cmp++;
        if (outstanding !== 3'd0 || axi_wbeat_addr !== 32'h0) begin
            n_err++; $display("FAIL rmid_state: outstanding %0d beat %h want 0 0", outstanding, axi_wbeat_addr);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        aw_send(32'h5000, 4'h8, 8'd1, 3'd3, 2'b01, 20);
        w_beats(2, 30);
        drain(20);
        repeat (3) begin @(posedge clk); #1; end
        n_cmp++;
        if (axi_bvalid !== 1'b0) begin
            n_err++; $display("FAIL rmid_stale: bvalid %b bid %h want no response", axi_bvalid, axi_bid);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        awaddr_in = '0; awid_in = '0; awlen_in = '0; awsize_in = '0; awburst_in = '0;
        awvalid_in = 1'b0;
        wdata_in = '0; wstrb_in = '0; wvalid_in = 1'b0;
        wready_in = 1'b1; bready_in = 1'b1;
        #1;
        test_reset();
        test_single_incr();
        test_wrap_fixed();
        test_back_pressure();
        test_data_first();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
